// File: rtl/fwd_unit_np_if.sv
// Decode-stage operand/hazard bundle between the pipeline control (master)
// and the forwarding unit (slave). Signal names follow the pipeline's own tags.
interface fwd_unit_np_if #(
  parameter int DW     = 64,
  parameter int RW     = 4,
  parameter int NPORTS = 2,
  parameter int CW     = 32
);
  logic                 d_valid_i;
  logic                 fwd_en_i;
  logic                 cnt_clr_i;
  logic [NPORTS*RW-1:0] d_src_i;
  logic [NPORTS*DW-1:0] d_rval_i;
  logic [RW-1:0]        e_dstE_i, E_dstM_i, M_dstE_i, M_dstM_i, W_dstE_i, W_dstM_i;
  logic [DW-1:0]        e_valE_i, M_valE_i, m_valM_i, W_valE_i, W_valM_i;

  logic [NPORTS*DW-1:0] fwd_val_o;
  logic [NPORTS*3-1:0]  fwd_sel_o;
  logic                 stall_d_o;
  logic                 bubble_e_o;
  logic [1:0]           state_o;
  logic                 err_o;
  logic [CW-1:0]        stall_cnt_o;
  logic [CW-1:0]        fwd_cnt_o;

  modport master (
    output d_valid_i, fwd_en_i, cnt_clr_i, d_src_i, d_rval_i,
           e_dstE_i, E_dstM_i, M_dstE_i, M_dstM_i, W_dstE_i, W_dstM_i,
           e_valE_i, M_valE_i, m_valM_i, W_valE_i, W_valM_i,
    input  fwd_val_o, fwd_sel_o, stall_d_o, bubble_e_o, state_o, err_o,
           stall_cnt_o, fwd_cnt_o
  );

  modport slave (
    input  d_valid_i, fwd_en_i, cnt_clr_i, d_src_i, d_rval_i,
           e_dstE_i, E_dstM_i, M_dstE_i, M_dstM_i, W_dstE_i, W_dstM_i,
           e_valE_i, M_valE_i, m_valM_i, W_valE_i, W_valM_i,
    output fwd_val_o, fwd_sel_o, stall_d_o, bubble_e_o, state_o, err_o,
           stall_cnt_o, fwd_cnt_o
  );
endinterface

// File: rtl/fwd_unit_np.sv
// Y86 decode-stage bypass network and hazard unit: per-port priority forwarding,
// load-use / interlock stall generation, hazard-class FSM, stall watchdog, counters.
module fwd_unit_np #(
  parameter int          DW        = 64,
  parameter int          RW        = 4,
  parameter int          NPORTS    = 2,
  parameter logic [RW-1:0] RNONE   = {RW{1'b1}},
  parameter int          CW        = 32,
  parameter int          MAX_STALL = 3
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  fwd_unit_np_if.slave   bus
);

  localparam int RUNW = $clog2(MAX_STALL + 2);
  localparam logic [RUNW-1:0] RUN_LIM = RUNW'(MAX_STALL);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_LU = 2'd1, ST_ILK = 2'd2} state_e;
  typedef enum logic [2:0] {
    SEL_RVAL = 3'd0, SEL_EVALE = 3'd1, SEL_MVALM = 3'd2,
    SEL_MVALE = 3'd3, SEL_WVALM = 3'd4, SEL_WVALE = 3'd5
  } sel_e;

  // An RNONE tag never matches, so an RNONE source can never hit either.
  function automatic logic tag_hit(input logic [RW-1:0] src, input logic [RW-1:0] tag);
    return (tag != RNONE) && (tag == src);
  endfunction

  logic [NPORTS-1:0]   w_lu_hit;
  logic [NPORTS-1:0]   w_raw_hit;
  logic [NPORTS*3-1:0] w_sel_all;
  logic                w_lu_haz, w_ilk_haz, w_stall, w_fwd_inc;
  state_e              r_state, w_state_nxt;
  logic [RUNW-1:0]     r_run;
  logic                r_err;
  logic [CW-1:0]       r_stall_cnt, r_fwd_cnt;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [RW-1:0] w_src;
    logic [DW-1:0] w_rval;
    logic [DW-1:0] w_pval;
    sel_e          w_psel;

    assign w_src  = bus.d_src_i[p*RW +: RW];
    assign w_rval = bus.d_rval_i[p*DW +: DW];

    always_comb begin
      // NOTE: defaults are assigned first so every path drives both outputs; no latch.
      w_psel = SEL_RVAL;
      w_pval = w_rval;
      if (bus.fwd_en_i) begin
        if (tag_hit(w_src, bus.e_dstE_i)) begin
          w_psel = SEL_EVALE;
          w_pval = bus.e_valE_i;
        end else if (tag_hit(w_src, bus.M_dstM_i)) begin
          w_psel = SEL_MVALM;
          w_pval = bus.m_valM_i;
        end else if (tag_hit(w_src, bus.M_dstE_i)) begin
          w_psel = SEL_MVALE;
          w_pval = bus.M_valE_i;
        end else if (tag_hit(w_src, bus.W_dstM_i)) begin
          w_psel = SEL_WVALM;
          w_pval = bus.W_valM_i;
        end else if (tag_hit(w_src, bus.W_dstE_i)) begin
          w_psel = SEL_WVALE;
          w_pval = bus.W_valE_i;
        end
      end
    end

    // E_dstM is a load still in flight: its value is not available to bypass yet.
    assign w_lu_hit[p]  = tag_hit(w_src, bus.E_dstM_i);
    assign w_raw_hit[p] = tag_hit(w_src, bus.e_dstE_i) | tag_hit(w_src, bus.E_dstM_i) |
                          tag_hit(w_src, bus.M_dstE_i) | tag_hit(w_src, bus.M_dstM_i) |
                          tag_hit(w_src, bus.W_dstE_i) | tag_hit(w_src, bus.W_dstM_i);

    assign w_sel_all[p*3 +: 3]       = w_psel;
    assign bus.fwd_val_o[p*DW +: DW] = w_pval;
  end

  assign w_lu_haz  = bus.d_valid_i & (|w_lu_hit);
  assign w_ilk_haz = bus.d_valid_i & ~bus.fwd_en_i & (|w_raw_hit);
  assign w_stall   = w_lu_haz | w_ilk_haz;
  assign w_fwd_inc = bus.d_valid_i & ~w_stall & (|w_sel_all);

  assign bus.fwd_sel_o  = w_sel_all;
  assign bus.stall_d_o  = w_stall;
  assign bus.bubble_e_o = w_stall;

  always_comb begin
    w_state_nxt = ST_RUN;
    if (w_ilk_haz)     w_state_nxt = ST_ILK;
    else if (w_lu_haz) w_state_nxt = ST_LU;
  end

  // NOTE: all state uses non-blocking assignment so every register samples pre-edge values;
  // the reset is asynchronous, so it sits in the sensitivity list and clears without a clock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_run <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_stall && (r_run >= RUN_LIM)) r_err <= 1'b1;
      if (!w_stall)       r_run <= '0;
      else if (~&r_run)   r_run <= r_run + 1'b1;
    end
  end

  // Clear wins over increment; both counters hold at all-ones.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else if (bus.cnt_clr_i) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_fwd_inc && ~&r_fwd_cnt) r_fwd_cnt   <= r_fwd_cnt + 1'b1;
    end
  end

  assign bus.state_o     = r_state;
  assign bus.err_o       = r_err;
  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.fwd_cnt_o   = r_fwd_cnt;

endmodule

// File: tb/tb_fwd_unit_np.sv
// Bench for fwd_unit_np: vector table plus hand sequences for watchdog,
// saturation, clear and mid-stall reset; expectations flow through a queue.
module tb_fwd_unit_np;

  localparam int CW     = 4;
  localparam int CMAX   = 15;
  localparam int MAXST  = 3;
  localparam logic [63:0] RVAL0 = 64'hA0, RVAL1 = 64'hB0;
  localparam logic [63:0] V_EE = 64'h11, V_MM = 64'h22, V_ME = 64'h33,
                          V_WM = 64'h44, V_WE = 64'h55;

  typedef struct {
    logic        valid;
    logic        fwd_en;
    logic        clr;
    logic [3:0]  src0;
    logic [3:0]  src1;
    logic [23:0] tags;  // eE, EM, ME, MM, WE, WM from MSB nibble down
    logic [2:0]  sel0;
    logic [2:0]  sel1;
    logic        stall;
    logic [1:0]  cls;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_unit_np_if #(.DW(64), .RW(4), .NPORTS(2), .CW(CW)) bus ();
  fwd_unit_np #(.DW(64), .RW(4), .NPORTS(2), .CW(CW), .MAX_STALL(MAXST)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  vec_t sb[$];
  vec_t vt[14];

  logic [1:0] m_state;
  logic       m_err;
  int         m_run, m_sc, m_fc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic f, input logic [3:0] s0,
                              input logic [3:0] s1, input logic [23:0] tg,
                              input logic [2:0] e0, input logic [2:0] e1,
                              input logic st, input logic [1:0] c);
    vec_t r;
    r.valid = v; r.fwd_en = f; r.clr = 1'b0; r.src0 = s0; r.src1 = s1; r.tags = tg;
    r.sel0 = e0; r.sel1 = e1; r.stall = st; r.cls = c;
    return r;
  endfunction

  function automatic logic [63:0] val_of(input logic [2:0] sel, input logic [63:0] rval);
    case (sel)
      3'd1:    return V_EE;
      3'd2:    return V_MM;
      3'd3:    return V_ME;
      3'd4:    return V_WM;
      3'd5:    return V_WE;
      default: return rval;
    endcase
  endfunction

  task automatic drive(input vec_t v);
    bus.d_valid_i = v.valid;
    bus.fwd_en_i  = v.fwd_en;
    bus.cnt_clr_i = v.clr;
    bus.d_src_i   = {v.src1, v.src0};
    bus.d_rval_i  = {RVAL1, RVAL0};
    bus.e_dstE_i  = v.tags[23:20];
    bus.E_dstM_i  = v.tags[19:16];
    bus.M_dstE_i  = v.tags[15:12];
    bus.M_dstM_i  = v.tags[11:8];
    bus.W_dstE_i  = v.tags[7:4];
    bus.W_dstM_i  = v.tags[3:0];
    bus.e_valE_i  = V_EE;
    bus.m_valM_i  = V_MM;
    bus.M_valE_i  = V_ME;
    bus.W_valM_i  = V_WM;
    bus.W_valE_i  = V_WE;
  endtask

  task automatic model_zero();
    m_state = 2'd0; m_err = 1'b0; m_run = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_update(input vec_t e);
    if (e.clr) begin
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (e.stall && m_sc < CMAX) m_sc++;
      if (e.valid && !e.stall && (e.sel0 != 3'd0 || e.sel1 != 3'd0) && m_fc < CMAX) m_fc++;
    end
    if (e.stall && m_run >= MAXST) m_err = 1'b1;
    m_run   = e.stall ? m_run + 1 : 0;
    m_state = e.cls;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".state"},     64'(bus.state_o),     64'(m_state));
    check({tag, ".err"},       64'(bus.err_o),       64'(m_err));
    check({tag, ".stall_cnt"}, 64'(bus.stall_cnt_o), 64'(m_sc));
    check({tag, ".fwd_cnt"},   64'(bus.fwd_cnt_o),   64'(m_fc));
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic apply(input vec_t v, input bit mid_rst, input string tag);
    vec_t e;
    drive(v);
    sb.push_back(v);
    #4;
    e = sb.pop_front();
    check({tag, ".sel0"},   64'(bus.fwd_sel_o[2:0]), 64'(e.sel0));
    check({tag, ".sel1"},   64'(bus.fwd_sel_o[5:3]), 64'(e.sel1));
    check({tag, ".val0"},   bus.fwd_val_o[63:0],     val_of(e.sel0, RVAL0));
    check({tag, ".val1"},   bus.fwd_val_o[127:64],   val_of(e.sel1, RVAL1));
    check({tag, ".stall"},  64'(bus.stall_d_o),      64'(e.stall));
    check({tag, ".bubble"}, 64'(bus.bubble_e_o),     64'(e.stall));
    if (mid_rst) begin
      rst_n = 1'b0;
      #1;
      model_zero();
      check_regs({tag, ".in_rst"});
      check({tag, ".stall_in_rst"}, 64'(bus.stall_d_o), 64'(e.stall));
      #1;
      rst_n = 1'b1;
    end
    @(posedge clk);
    #1;
    model_update(e);
    check_regs(tag);
  endtask

  task automatic do_reset(input vec_t idle, input string tag);
    drive(idle);
    rst_n = 1'b0;
    #1;
    model_zero();
    check_regs({tag, ".rst"});
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_update(idle);
    check_regs({tag, ".post"});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle, vc;

    vt[0]  = mk(1, 1, 4'h3, 4'hF, 24'h3FF3FF, 3'd1, 3'd0, 0, 2'd0);  // e beats M
    vt[1]  = mk(1, 1, 4'h3, 4'hF, 24'hFFF3FF, 3'd2, 3'd0, 0, 2'd0);  // M_dstM only
    vt[2]  = mk(1, 1, 4'h3, 4'hF, 24'hFFFF3F, 3'd5, 3'd0, 0, 2'd0);  // W_dstE only
    vt[3]  = mk(1, 1, 4'h2, 4'h5, 24'hFF5FF2, 3'd4, 3'd3, 0, 2'd0);  // independent ports
    vt[4]  = mk(1, 1, 4'hF, 4'hF, 24'hFFFFFF, 3'd0, 3'd0, 0, 2'd0);  // all RNONE
    vt[5]  = mk(1, 1, 4'h1, 4'h7, 24'hF7FFFF, 3'd0, 3'd0, 1, 2'd1);  // load-use on port 1
    vt[6]  = mk(0, 1, 4'h1, 4'h7, 24'hF7FFFF, 3'd0, 3'd0, 0, 2'd0);  // load-use, D empty
    vt[7]  = mk(1, 0, 4'h4, 4'hF, 24'hFFFF4F, 3'd0, 3'd0, 1, 2'd2);  // interlock on W_dstE
    vt[8]  = mk(1, 1, 4'h6, 4'h6, 24'hFFF66F, 3'd2, 3'd2, 0, 2'd0);  // same reg both ports
    vt[9]  = mk(1, 1, 4'h8, 4'h9, 24'hFF8899, 3'd2, 3'd4, 0, 2'd0);  // M and W dstM priority
    vt[10] = mk(0, 0, 4'h4, 4'hF, 24'hFFFF4F, 3'd0, 3'd0, 0, 2'd0);  // interlock, D empty
    vt[11] = mk(1, 1, 4'h3, 4'hF, 24'hF3F3FF, 3'd2, 3'd0, 1, 2'd1);  // load-use with bypass
    vt[12] = mk(1, 0, 4'h1, 4'hA, 24'hAFFFFF, 3'd0, 3'd0, 1, 2'd2);  // interlock on e_dstE
    vt[13] = mk(1, 1, 4'hF, 4'h0, 24'h0FFFFF, 3'd0, 3'd1, 0, 2'd0);  // RNONE src vs RNONE tags

    idle = vt[4];
    idle.valid = 1'b0;

    drive(idle);
    model_zero();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) apply(vt[i], 1'b0, $sformatf("vec%0d", i));

    // Interlock held four cycles: watchdog trips on the 4th edge and stays set.
    for (int i = 0; i < 4; i++) apply(vt[7], 1'b0, $sformatf("wd%0d", i));
    check("wd.err_set", 64'(bus.err_o), 64'd1);
    for (int i = 0; i < 2; i++) apply(vt[4], 1'b0, $sformatf("wd_clr%0d", i));
    do_reset(idle, "wd");

    // Mode change mid-run does not restart the stall run.
    apply(vt[5], 1'b0, "mode0");
    apply(vt[5], 1'b0, "mode1");
    apply(vt[7], 1'b0, "mode2");
    apply(vt[7], 1'b0, "mode3");
    do_reset(idle, "mode");

    // 17 stalls saturate a 4-bit counter; clear during a stall wins.
    for (int i = 0; i < 17; i++) apply(vt[5], 1'b0, $sformatf("sat%0d", i));
    check("sat.stall_cnt", 64'(bus.stall_cnt_o), 64'(CMAX));
    vc = vt[5];
    vc.clr = 1'b1;
    apply(vc, 1'b0, "clr");
    apply(vt[5], 1'b0, "post_clr0");
    apply(vt[5], 1'b0, "post_clr1");

    // Reset during a stall clears registers at once; counting restarts after release.
    apply(vt[5], 1'b1, "midrst");
    apply(vt[5], 1'b0, "after_rst");

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_unit_np.md
# fwd_unit_np

Parametrised forwarding and hazard unit for the Y86 pipeline decode stage. It serves NPORTS register read ports, each resolved by a fixed-priority bypass network over the E, M and W stages. It detects load-use hazards and, when forwarding is disabled, full RAW interlocks, and drives the decode stall and execute bubble. It also keeps a registered hazard-class state, a stall-length watchdog and saturating performance counters.

## Interface
Parameters:
- DW, 64, data width
- RW, 4, register address width
- NPORTS, 2, number of decode read ports (port 0 = srcA, port 1 = srcB)
- RNONE, 4'hF, "no register" code; never matches anything
- CW, 32, performance counter width
- MAX_STALL, 3, longest legal consecutive stall run

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- d_valid_i  in  1  D stage holds a real instruction
- fwd_en_i  in  1  1 = forwarding mode, 0 = interlock mode
- cnt_clr_i  in  1  synchronous clear of all counters
- d_src_i  in  NPORTS*RW  source register per port; port p is at [p*RW +: RW]
- d_rval_i  in  NPORTS*DW  register file read value per port
- e_dstE_i, E_dstM_i, M_dstE_i, M_dstM_i, W_dstE_i, W_dstM_i  in  RW each  stage destination tags
- e_valE_i, M_valE_i, m_valM_i, W_valE_i, W_valM_i  in  DW each  stage result values
- fwd_val_o  out  NPORTS*DW  resolved operand per port
- fwd_sel_o  out  NPORTS*3  source code per port: 0 rval, 1 e_valE, 2 m_valM, 3 M_valE, 4 W_valM, 5 W_valE
- stall_d_o  out  1  hold F/D registers
- bubble_e_o  out  1  inject bubble into E
- state_o  out  2  registered hazard class: 0 RUN, 1 LU, 2 ILK
- err_o  out  1  sticky watchdog error
- stall_cnt_o, fwd_cnt_o  out  CW each  saturating counters

## Operation
- Forwarding mode (fwd_en_i=1):
  - Each port compares its own d_src against tags in strict priority: e_dstE→e_valE, M_dstM→m_valM, M_dstE→M_valE, W_dstM→W_valM, W_dstE→W_valE, else d_rval.
  - Every comparison uses the port's own source.
  - A tag equal to RNONE never matches. A port with src=RNONE selects 0.
- Load-use hazard: d_valid_i=1, E_dstM≠RNONE, and E_dstM equals any port src ≠ RNONE.
  - Result: stall_d_o=bubble_e_o=1.
  - fwd_val_o is still computed by the normal priority; the pipeline discards it.
- Interlock mode (fwd_en_i=0):
  - fwd_val_o=d_rval and fwd_sel_o=0 on all ports.
  - Hazard when d_valid_i=1 and any port src≠RNONE matches any of the six tags. Result: stall_d_o=bubble_e_o=1.
- d_valid_i=0: stall_d_o=bubble_e_o=0. Forwarding outputs still computed.
- Ports are independent. Two ports naming the same register receive identical value and sel.
- FSM, updated each edge from the current cycle's hazard:
  - Next state is ILK if there is an interlock hazard, else LU if there is a load-use hazard, else RUN.
  - state_o shows the previous cycle's class.
- Watchdog:
  - run counter (width ≥ clog2(MAX_STALL+2)) increments while stall_d_o=1 and resets to 0 otherwise. It saturates.
  - When run reaches MAX_STALL and stall_d_o is still 1, err_o sets. err_o stays set until reset.
- Counters:
  - stall_cnt increments each cycle stall_d_o=1.
  - fwd_cnt increments each cycle with d_valid_i=1, stall_d_o=0 and any port fwd_sel≠0.
  - Both saturate at all-ones. cnt_clr_i zeroes both and overrides any increment that cycle.

## Timing
- fwd_val_o, fwd_sel_o, stall_d_o and bubble_e_o are combinational: zero latency, valid in the same cycle as their inputs.
- state_o, err_o and the counters are registered and update on the rising clk_i edge following the causing cycle.
- Reset (rst_n_i=0, asynchronous):
  - Registered outputs and internals go to 0 immediately: state_o=RUN, err_o=0, run=0, stall_cnt_o=0, fwd_cnt_o=0.
  - Combinational outputs keep following their inputs.
- Reset asserted mid-stall clears run and state_o at once. After release, counting restarts from 0.
- fwd_en_i may change on any cycle and takes effect combinationally. The run counter is not cleared by a mode change.
- Saturated counter plus increment holds all-ones. Saturated counter plus cnt_clr_i goes to 0.

## Test plan
- Priority: src0=3, e_dstE=3 (valE=0x11), M_dstM=3 (valM=0x22) → fwd_val0=0x11, sel0=1. Remove the e match → 0x22, sel0=2. Only W_dstE=3 → sel0=5.
- Per-port independence: src0=2, src1=5, M_dstE=5, W_dstM=2 → sel0=4, sel1=3. Next edge fwd_cnt_o=1.
- RNONE: src0=RNONE and all tags=RNONE → sel0=0, fwd_val0=d_rval0, no stall.
- Load-use: E_dstM=7, src1=7, d_valid_i=1 → stall_d_o=bubble_e_o=1 same cycle. Next edge state_o=1, stall_cnt_o=1.
- Interlock watchdog: fwd_en_i=0, W_dstE=4 and src0=4 held for 4 cycles → stall each cycle, state_o=2. err_o=1 after the 4th edge, and remains 1 after the hazard clears. Reset → err_o=0.
- Counter saturation/clear: CW=4, 17 stall cycles → stall_cnt_o=15. cnt_clr_i pulse during a stall → 0 on the next edge. Asynchronous reset mid-stall → all registered outputs 0 before the next edge.
